cpu: RTL and testbench
======================

CPU -- requirements
Module: cpu

Interface
REQ-001 Ports: clk  input  1  rising-edge clock; all state updates on the rising edge.
REQ-002 Ports: reset  input  1  asynchronous, active-high.
REQ-003 No other ports; program and data are preloaded through hierarchical access.
REQ-004 Parameter RESET_PC, default 32'h00001000, fetch address after reset.
REQ-005 Parameter IMEM_WORDS, default 4096, instruction memory depth in 32-bit words.
REQ-006 Parameter DMEM_WORDS, default 4096, data memory depth in 32-bit words.
REQ-007 Required hierarchy for the bench: fetch_stage.memory_ins.instr_mem[], mem_stage_inst.data_mem.data_mem[], register_table.data_register[0:31], program_counter.
REQ-008 Required mem_stage_inst signals: mem_write_en, mem_addr, is_load_in, rd_in[4:0], alu_result_in, load_data, stall_req.
REQ-009 Required top-level write-back signals: wb_write_reg, wb_register_d[4:0], wb_data_out.

Function
REQ-010 Classic 5-stage in-order RV32I pipeline: IF, ID, EX, MEM, WB; at most one instruction per stage.
REQ-011 Supported instructions: ADD, SUB, AND, OR, XOR, SLT, ADDI, LW, SW, BEQ, BNE, BLT, BGE, JAL; any other encoding executes as a NOP.
REQ-012 Memory indexing: instr_mem[pc>>2] and data_mem[addr>>2]; word accesses only; addresses wrap modulo depth.
REQ-013 IF reads instruction memory combinationally at program_counter; PC advances by 4 each unstalled cycle.
REQ-014 Branches and JAL resolve in EX: taken target = PC of instruction + sign-extended immediate; the two younger instructions are flushed to NOPs.
REQ-015 JAL writes PC+4 to rd; `JAL x0,0` spins forever without side effects.
REQ-016 Register x0 reads as 0; writes to it are discarded.
REQ-017 Register file writes in WB; a same-cycle read of the written register returns the new value.
REQ-018 Load-use hazard: an instruction needing the rd of an LW in EX stalls IF/ID one cycle and inserts a bubble into EX.
REQ-019 Data memory is single-cycle: stall_req is always 0, and load_data is valid in the same cycle as the MEM-stage address.
REQ-020 SW writes data_mem at MEM on the rising edge when mem_write_en=1; mem_addr equals the ALU effective address.
REQ-021 All arithmetic is 32-bit two's complement with wrap-around; BLT and SLT are signed.

Reset
REQ-022 While reset=1: program_counter=RESET_PC, every pipeline register holds a NOP (no register write, no memory write), and all 32 registers are 0.
REQ-023 Memories are not cleared by reset; their contents persist across reset.
REQ-024 A reset asserted mid-operation aborts all in-flight instructions; the first fetch after release is at RESET_PC.

Configuration
REQ-025 Macro FORWARDING_EN, when defined, enables EX/MEM and MEM/WB operand forwarding into EX, with load-use costing one bubble.
REQ-026 Without FORWARDING_EN, ID stalls while any in-flight instruction targets a source register, until that writer has completed WB.
REQ-027 Architectural results are identical in both configurations; only cycle counts differ.

Verification
REQ-028 Array sum: data_mem[0x40+i]=i for i=0..127; loop LW x8 / ADD x2 / ADDI / ADDI / BLT at 0x1000, then SW x2,0x300(x0) -> data_mem[0xC0]=8128, x2=8128, exactly 128 distinct loads, and running sum correct at every x2 write-back.
REQ-029 Load-use: LW x8 immediately followed by ADD x2,x2,x8 -> sum uses the loaded value; one bubble is inserted with FORWARDING_EN.
REQ-030 Taken BLT at the loop end -> the two following instructions (for example SW) never reach MEM with a write enabled; the fall-through SW executes exactly once.
REQ-031 ADDI x0,x0,5 followed by ADD x1,x0,x0 -> x1=0.
REQ-032 Pulse reset mid-loop -> PC=0x1000 and registers are 0; the rerun still yields data_mem[0xC0]=8128.

Source files
------------

// File: rtl/cpu.sv
// cpu: five-stage in-order RV32I subset pipeline (IF, ID, EX, MEM, WB).
// Supported: ADD SUB AND OR XOR SLT ADDI LW SW BEQ BNE BLT BGE JAL. Any other encoding is a NOP.
// Branches and JAL resolve in EX and flush the two younger instructions.
// Ports: clk (rising edge), reset (asynchronous, active-high). Program and data are preloaded hierarchically.
// Parameters: RESET_PC, IMEM_WORDS, DMEM_WORDS. Memory depths must be powers of two; addresses wrap.
// Build option: define FORWARDING_EN to forward EX/MEM and MEM/WB results into EX.
//   Without it, ID interlocks on every in-flight writer.

// imem: instruction word store; read is combinational.
// Latency: 0 cycles on the read path.
// Backpressure: none; the write port exists only so the array has a driver.
module imem #(
  parameter int WORDS = 4096
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(WORDS)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);
  logic [31:0] instr_mem [0:WORDS-1];

  always_ff @(posedge clk) begin
    if (we) instr_mem[addr] <= wdata;
  end

  assign rdata = instr_mem[addr];
endmodule

// dmem: data word store.
// Latency: combinational read; the write lands on the rising edge.
// Backpressure: none; always ready.
module dmem #(
  parameter int WORDS = 4096
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(WORDS)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);
  logic [31:0] data_mem [0:WORDS-1];

  always_ff @(posedge clk) begin
    if (we) data_mem[addr] <= wdata;
  end

  assign rdata = data_mem[addr];
endmodule

// regfile: 32 x 32-bit register file.
// Latency: combinational reads, with write-through of the same-cycle WB value.
// Backpressure: none. x0 reads as zero and writes to it are dropped.
module regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] data_register [0:31];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) data_register[i] <= '0;
    end else if (we && wa != 5'd0) begin
      data_register[wa] <= wd;
    end
  end

  assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 :
                    (we && wa == rs1_addr) ? wd : data_register[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 :
                    (we && wa == rs2_addr) ? wd : data_register[rs2_addr];
endmodule

// fetch_stage: instruction fetch at the current program counter.
// Latency: combinational; the instruction is valid in the same cycle as pc.
// Backpressure: none; stalls are applied by holding pc upstream.
module fetch_stage #(
  parameter int IMEM_WORDS = 4096
) (
  input  logic        clk,
  input  logic [31:0] pc,
  output logic [31:0] instr
);
  localparam int IAW = $clog2(IMEM_WORDS);

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc[31:IAW+2], pc[1:0]};

  imem #(.WORDS(IMEM_WORDS)) memory_ins (
    .clk   (clk),
    .we    (1'b0),
    .addr  (pc[IAW+1:2]),
    .wdata (32'd0),
    .rdata (instr)
  );
endmodule

// mem_stage: data memory access; selects the load data or the ALU result for WB.
// Latency: single cycle. load_data is valid in the same cycle as mem_addr.
// Backpressure: never; stall_req is tied low.
module mem_stage #(
  parameter int DMEM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        mem_write_en,
  input  logic [31:0] mem_addr,
  input  logic [31:0] store_data,
  input  logic        is_load_in,
  input  logic [4:0]  rd_in,
  input  logic [31:0] alu_result_in,
  output logic [31:0] result_out,
  output logic [4:0]  rd_out
);
  localparam int DAW = $clog2(DMEM_WORDS);

  logic [31:0] load_data;
  logic        stall_req;

  assign stall_req = 1'b0;

  dmem #(.WORDS(DMEM_WORDS)) data_mem (
    .clk   (clk),
    .we    (mem_write_en),
    .addr  (mem_addr[DAW+1:2]),
    .wdata (store_data),
    .rdata (load_data)
  );

  assign result_out = is_load_in ? load_data : alu_result_in;
  assign rd_out     = rd_in;

  logic unused_bits;
  assign unused_bits = ^{mem_addr[31:DAW+2], mem_addr[1:0], stall_req};
endmodule

// cpu: pipeline top.
// Latency: 5 stages; load-use costs one bubble with forwarding and more without it.
// Backpressure: ID stalls IF/ID on hazards; a taken branch or JAL flushes IF/ID and ID/EX.
module cpu #(
  parameter logic [31:0] RESET_PC   = 32'h00001000,
  parameter int          IMEM_WORDS = 4096,
  parameter int          DMEM_WORDS = 4096
) (
  input logic clk,
  input logic reset
);
  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_ADDI,
    OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_JAL
  } op_t;

  typedef struct packed {
    op_t         op;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
  } idex_t;

  typedef struct packed {
    op_t         op;
    logic [31:0] result;
    logic [31:0] store_val;
    logic [4:0]  rd;
    logic        reg_write;
  } exmem_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  logic [31:0] program_counter;
  logic [31:0] if_instr;
  logic [31:0] ifid_pc, ifid_instr;
  idex_t       idex, id_next;
  exmem_t      exmem;
  logic        wb_write_reg;
  logic [4:0]  wb_register_d;
  logic [31:0] wb_data_out;
  logic [31:0] rf_rd1, rf_rd2, mem_result;
  logic [4:0]  mem_rd;
  logic        id_use_rs1, id_use_rs2, stall;
  logic [31:0] ex_a, ex_b, ex_result, ex_target;
  logic        ex_taken;

  fetch_stage #(.IMEM_WORDS(IMEM_WORDS)) fetch_stage (
    .clk(clk), .pc(program_counter), .instr(if_instr)
  );

  regfile register_table (
    .clk(clk), .reset(reset),
    .rs1_addr(ifid_instr[19:15]), .rs2_addr(ifid_instr[24:20]),
    .rs1_data(rf_rd1), .rs2_data(rf_rd2),
    .we(wb_write_reg), .wa(wb_register_d), .wd(wb_data_out)
  );

  // Decode into the ID/EX payload. Unsupported encodings become OP_NOP.
  always_comb begin
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc = ifid_instr[6:0];
    f3  = ifid_instr[14:12];
    f7  = ifid_instr[31:25];
    id_next = '0;
    id_next.op = OP_NOP;
    case (opc)
      7'b0110011: begin
        case ({f7, f3})
          {7'h00, 3'b000}: id_next.op = OP_ADD;
          {7'h20, 3'b000}: id_next.op = OP_SUB;
          {7'h00, 3'b111}: id_next.op = OP_AND;
          {7'h00, 3'b110}: id_next.op = OP_OR;
          {7'h00, 3'b100}: id_next.op = OP_XOR;
          {7'h00, 3'b010}: id_next.op = OP_SLT;
          default:         id_next.op = OP_NOP;
        endcase
      end
      7'b0010011: if (f3 == 3'b000) id_next.op = OP_ADDI;
      7'b0000011: if (f3 == 3'b010) id_next.op = OP_LW;
      7'b0100011: if (f3 == 3'b010) id_next.op = OP_SW;
      7'b1100011: begin
        case (f3)
          3'b000:  id_next.op = OP_BEQ;
          3'b001:  id_next.op = OP_BNE;
          3'b100:  id_next.op = OP_BLT;
          3'b101:  id_next.op = OP_BGE;
          default: id_next.op = OP_NOP;
        endcase
      end
      7'b1101111: id_next.op = OP_JAL;
      default:    id_next.op = OP_NOP;
    endcase

    case (opc)
      7'b0100011: id_next.imm = {{20{ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
      7'b1100011: id_next.imm = {{19{ifid_instr[31]}}, ifid_instr[31], ifid_instr[7],
                                 ifid_instr[30:25], ifid_instr[11:8], 1'b0};
      7'b1101111: id_next.imm = {{11{ifid_instr[31]}}, ifid_instr[31], ifid_instr[19:12],
                                 ifid_instr[20], ifid_instr[30:21], 1'b0};
      default:    id_next.imm = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
    endcase

    id_next.pc      = ifid_pc;
    id_next.rs1_val = rf_rd1;
    id_next.rs2_val = rf_rd2;
    id_next.rs1     = ifid_instr[19:15];
    id_next.rs2     = ifid_instr[24:20];
    id_next.rd      = ifid_instr[11:7];
    // Writes to x0 are dropped at decode so neither hazard nor forwarding logic ever matches x0.
    id_next.reg_write = (id_next.op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT,
                                            OP_ADDI, OP_LW, OP_JAL}) && (id_next.rd != 5'd0);
  end

  assign id_use_rs1 = (id_next.op != OP_NOP) && (id_next.op != OP_JAL);
  assign id_use_rs2 = id_next.op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT,
                                         OP_SW, OP_BEQ, OP_BNE, OP_BLT, OP_BGE};

  logic hit_ex;
  assign hit_ex = idex.reg_write && ((id_use_rs1 && id_next.rs1 == idex.rd) ||
                                     (id_use_rs2 && id_next.rs2 == idex.rd));

`ifdef FORWARDING_EN
  // Only a load in EX cannot be forwarded in time. After one bubble it sits in WB,
  // and the MEM/WB path covers it.
  assign stall = hit_ex && (idex.op == OP_LW);

  always_comb begin
    ex_a = idex.rs1_val;
    ex_b = idex.rs2_val;
    if (exmem.reg_write && exmem.rd == idex.rs1)        ex_a = exmem.result;
    else if (wb_write_reg && wb_register_d == idex.rs1) ex_a = wb_data_out;
    if (exmem.reg_write && exmem.rd == idex.rs2)        ex_b = exmem.result;
    else if (wb_write_reg && wb_register_d == idex.rs2) ex_b = wb_data_out;
  end
`else
  // A writer in WB is already visible through the register-file write-through.
  logic hit_mem;
  assign hit_mem = exmem.reg_write && ((id_use_rs1 && id_next.rs1 == exmem.rd) ||
                                       (id_use_rs2 && id_next.rs2 == exmem.rd));
  assign stall = hit_ex || hit_mem;
  assign ex_a  = idex.rs1_val;
  assign ex_b  = idex.rs2_val;

  logic unused_src;
  assign unused_src = ^{idex.rs1, idex.rs2};
`endif

  always_comb begin
    ex_result = '0;
    ex_taken  = 1'b0;
    ex_target = idex.pc + idex.imm;
    case (idex.op)
      OP_ADD:  ex_result = ex_a + ex_b;
      OP_SUB:  ex_result = ex_a - ex_b;
      OP_AND:  ex_result = ex_a & ex_b;
      OP_OR:   ex_result = ex_a | ex_b;
      OP_XOR:  ex_result = ex_a ^ ex_b;
      OP_SLT:  ex_result = {31'd0, $signed(ex_a) < $signed(ex_b)};
      OP_ADDI, OP_LW, OP_SW: ex_result = ex_a + idex.imm;
      OP_BEQ:  ex_taken = (ex_a == ex_b);
      OP_BNE:  ex_taken = (ex_a != ex_b);
      OP_BLT:  ex_taken = ($signed(ex_a) < $signed(ex_b));
      OP_BGE:  ex_taken = ($signed(ex_a) >= $signed(ex_b));
      OP_JAL:  begin ex_result = idex.pc + 32'd4; ex_taken = 1'b1; end
      default: ;
    endcase
  end

  mem_stage #(.DMEM_WORDS(DMEM_WORDS)) mem_stage_inst (
    .clk(clk), .mem_write_en(exmem.op == OP_SW), .mem_addr(exmem.result),
    .store_data(exmem.store_val), .is_load_in(exmem.op == OP_LW), .rd_in(exmem.rd),
    .alu_result_in(exmem.result), .result_out(mem_result), .rd_out(mem_rd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      program_counter <= RESET_PC;
      ifid_pc         <= '0;
      ifid_instr      <= NOP_INSTR;
      idex            <= '0;
      exmem           <= '0;
      wb_write_reg    <= 1'b0;
      wb_register_d   <= '0;
      wb_data_out     <= '0;
    end else begin
      if (ex_taken) begin
        program_counter <= ex_target;
        ifid_pc         <= '0;
        ifid_instr      <= NOP_INSTR;
        idex            <= '0;
      end else if (stall) begin
        idex <= '0;
      end else begin
        program_counter <= program_counter + 32'd4;
        ifid_pc         <= program_counter;
        ifid_instr      <= if_instr;
        idex            <= id_next;
      end
      exmem.op        <= idex.op;
      exmem.result    <= ex_result;
      exmem.store_val <= ex_b;
      exmem.rd        <= idex.rd;
      exmem.reg_write <= idex.reg_write;
      wb_write_reg    <= exmem.reg_write;
      wb_register_d   <= mem_rd;
      wb_data_out     <= mem_result;
    end
  end
endmodule

// File: tb/tb_cpu.sv
// tb_cpu: directed program run on cpu.
// The program covers an array-sum loop with a load-use pair, the x0 rules, JAL, the ALU ops and branch outcomes.
// A reset pulse lands mid-loop and the program then reruns from the start.
module tb_cpu;
  logic clk;
  logic reset;

  cpu dut (.clk(clk), .reset(reset));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  // Scoreboard state, cleared whenever reset is seen.
  logic [31:0] sum_model;
  int          x2_writes, loads, distinct_loads, stores;
  logic [31:0] store_addr;
  logic [127:0] seen;

  always @(negedge clk) begin
    if (reset) begin
      sum_model = 0; x2_writes = 0; loads = 0; distinct_loads = 0;
      stores = 0; store_addr = 0; seen = '0;
    end else begin
      if (dut.wb_write_reg && dut.wb_register_d == 5'd2) begin
        logic [31:0] exp_sum;
        exp_sum = sum_model + x2_writes;
        check($sformatf("x2_wb_%0d", x2_writes), dut.wb_data_out, exp_sum);
        sum_model = exp_sum;
        x2_writes++;
      end
      if (dut.mem_stage_inst.is_load_in) begin
        logic [31:0] a;
        a = dut.mem_stage_inst.mem_addr;
        loads++;
        if (a >= 32'h100 && a < 32'h300 && a[1:0] == 2'b00) begin
          int idx;
          idx = int'((a - 32'h100) >> 2);
          if (!seen[idx]) begin
            seen[idx] = 1'b1;
            distinct_loads++;
          end
        end
      end
      if (dut.mem_stage_inst.mem_write_en) begin
        stores++;
        store_addr = dut.mem_stage_inst.mem_addr;
      end
    end
  end

  logic [31:0] prog [0:27];
  logic [31:0] exp_regs [0:31];

  initial begin
    bit done;
    reset = 1'b1;

    prog[0]  = enc_i(12'h200, 5'd0, 3'b000, 5'd3, 7'b0010011);   // ADDI x3,x0,0x200
    prog[1]  = enc_i(12'h100, 5'd1, 3'b010, 5'd8, 7'b0000011);   // LW x8,0x100(x1)
    prog[2]  = enc_r(7'h00, 5'd8, 5'd2, 3'b000, 5'd2);            // ADD x2,x2,x8
    prog[3]  = enc_i(12'd4, 5'd1, 3'b000, 5'd1, 7'b0010011);     // ADDI x1,x1,4
    prog[4]  = enc_i(12'd1, 5'd9, 3'b000, 5'd9, 7'b0010011);     // ADDI x9,x9,1
    prog[5]  = enc_b(13'h1FF0, 5'd3, 5'd1, 3'b100);               // BLT x1,x3,-16
    prog[6]  = enc_s(12'h300, 5'd2, 5'd0);                        // SW x2,0x300(x0)
    prog[7]  = enc_i(12'd5, 5'd0, 3'b000, 5'd0, 7'b0010011);     // ADDI x0,x0,5
    prog[8]  = enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd1);            // ADD x1,x0,x0
    prog[9]  = enc_j(21'd8, 5'd5);                                // JAL x5,+8
    prog[10] = enc_i(12'd1, 5'd0, 3'b000, 5'd6, 7'b0010011);     // ADDI x6,x0,1 (skipped)
    prog[11] = enc_i(12'hFF9, 5'd0, 3'b000, 5'd10, 7'b0010011);  // ADDI x10,x0,-7
    prog[12] = enc_i(12'd3, 5'd0, 3'b000, 5'd11, 7'b0010011);    // ADDI x11,x0,3
    prog[13] = enc_r(7'h20, 5'd11, 5'd10, 3'b000, 5'd12);         // SUB x12
    prog[14] = enc_r(7'h00, 5'd11, 5'd10, 3'b111, 5'd13);         // AND x13
    prog[15] = enc_r(7'h00, 5'd11, 5'd10, 3'b110, 5'd14);         // OR  x14
    prog[16] = enc_r(7'h00, 5'd11, 5'd10, 3'b100, 5'd15);         // XOR x15
    prog[17] = enc_r(7'h00, 5'd11, 5'd10, 3'b010, 5'd16);         // SLT x16,x10,x11
    prog[18] = enc_r(7'h00, 5'd10, 5'd11, 3'b010, 5'd17);         // SLT x17,x11,x10
    prog[19] = enc_b(13'd8, 5'd11, 5'd10, 3'b000);                // BEQ not taken
    prog[20] = enc_i(12'd1, 5'd0, 3'b000, 5'd18, 7'b0010011);    // ADDI x18,x0,1
    prog[21] = enc_b(13'd8, 5'd11, 5'd10, 3'b001);                // BNE taken
    prog[22] = enc_i(12'd1, 5'd0, 3'b000, 5'd19, 7'b0010011);    // ADDI x19 (flushed)
    prog[23] = enc_b(13'd8, 5'd10, 5'd11, 3'b101);                // BGE x11,x10 taken
    prog[24] = enc_i(12'd1, 5'd0, 3'b000, 5'd20, 7'b0010011);    // ADDI x20 (flushed)
    prog[25] = enc_b(13'd8, 5'd11, 5'd10, 3'b101);                // BGE x10,x11 not taken
    prog[26] = enc_i(12'd1, 5'd0, 3'b000, 5'd21, 7'b0010011);    // ADDI x21,x0,1
    prog[27] = enc_j(21'd0, 5'd0);                                // JAL x0,0

    for (int i = 0; i < 64; i++) dut.fetch_stage.memory_ins.instr_mem[32'h400 + i] = 32'h00000013;
    for (int i = 0; i < 28; i++) dut.fetch_stage.memory_ins.instr_mem[32'h400 + i] = prog[i];
    for (int i = 0; i < 128; i++) dut.mem_stage_inst.data_mem.data_mem[32'h40 + i] = i;
    dut.mem_stage_inst.data_mem.data_mem[32'hC0] = 32'hDEADBEEF;

    repeat (3) @(negedge clk);
    check("reset_pc", dut.program_counter, 32'h00001000);
    check("reset_wb_write", {31'd0, dut.wb_write_reg}, 32'd0);
    check("reset_mem_we", {31'd0, dut.mem_stage_inst.mem_write_en}, 32'd0);
    check("stall_req_low", {31'd0, dut.mem_stage_inst.stall_req}, 32'd0);
    reset = 1'b0;

    // Run part-way into the loop, then pulse reset.
    repeat (150) @(negedge clk);
    check("x2_nonzero_midloop", {31'd0, dut.register_table.data_register[2] != 0}, 32'd1);
    reset = 1'b1;
    #2;
    check("midreset_pc", dut.program_counter, 32'h00001000);
    check("midreset_x1", dut.register_table.data_register[1], 32'd0);
    check("midreset_x2", dut.register_table.data_register[2], 32'd0);
    check("midreset_x8", dut.register_table.data_register[8], 32'd0);
    check("midreset_x9", dut.register_table.data_register[9], 32'd0);
    check("midreset_wb_write", {31'd0, dut.wb_write_reg}, 32'd0);
    check("midreset_mem_we", {31'd0, dut.mem_stage_inst.mem_write_en}, 32'd0);
    check("mem_persist_c0", dut.mem_stage_inst.data_mem.data_mem[32'hC0], 32'hDEADBEEF);
    check("mem_persist_45", dut.mem_stage_inst.data_mem.data_mem[32'h45], 32'd5);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    done = 1'b0;
    for (int c = 0; c < 20000 && !done; c++) begin
      @(negedge clk);
      if (dut.program_counter == 32'h0000106C) done = 1'b1;
    end
    check("program_completes", {31'd0, done}, 32'd1);
    repeat (10) @(negedge clk);

    check("dmem_sum", dut.mem_stage_inst.data_mem.data_mem[32'hC0], 32'd8128);
    check("load_count", loads, 128);
    check("distinct_loads", distinct_loads, 128);
    check("x2_write_count", x2_writes, 128);
    check("store_count", stores, 1);
    check("store_addr", store_addr, 32'h300);

    for (int i = 0; i < 32; i++) exp_regs[i] = 32'd0;
    exp_regs[2]  = 32'd8128;
    exp_regs[3]  = 32'h200;
    exp_regs[5]  = 32'h1028;
    exp_regs[8]  = 32'd127;
    exp_regs[9]  = 32'd128;
    exp_regs[10] = 32'hFFFFFFF9;
    exp_regs[11] = 32'd3;
    exp_regs[12] = 32'hFFFFFFF6;
    exp_regs[13] = 32'd1;
    exp_regs[14] = 32'hFFFFFFFB;
    exp_regs[15] = 32'hFFFFFFFA;
    exp_regs[16] = 32'd1;
    exp_regs[18] = 32'd1;
    exp_regs[21] = 32'd1;
    for (int i = 0; i < 32; i++)
      check($sformatf("final_x%0d", i), dut.register_table.data_register[i], exp_regs[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
